// File: rtl/qerv_ibus_prefetch.sv
// Purpose : sequential instruction prefetch FIFO between the core ibus and the instruction memory.
// Latency : buffered hit 1 cycle; miss from idle = memory latency + 3 cycles.
// Backpres: core waits for o_cpu_ack; memory fetch issued only when a FIFO slot is guaranteed.
//
// Ports:
//   clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_flush                      one-cycle pulse: empty FIFO, drop in-flight fetch, stop prefetch
//   i_cpu_adr/i_cpu_cyc          core fetch request (adr bits [1:0] ignored)
//   o_cpu_rdt/o_cpu_ack          instruction word and one-cycle registered acknowledge
//   o_mem_adr/o_mem_cyc          Wishbone classic fetch request, held until i_mem_ack
//   i_mem_rdt/i_mem_ack          Wishbone read data and acknowledge
module qerv_ibus_prefetch #(
   parameter int    DEPTH          = 2,
   parameter string RESET_STRATEGY = "MINI"
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic [31:0] i_cpu_adr,
   input  logic        i_cpu_cyc,
   output logic [31:0] o_cpu_rdt,
   output logic        o_cpu_ack,
   output logic [31:0] o_mem_adr,
   output logic        o_mem_cyc,
   input  logic [31:0] i_mem_rdt,
   input  logic        i_mem_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // control state
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          mem_cyc_q, mem_cyc_d;
   logic          drop_q, drop_d;
   logic          started_q, started_d;
   logic          cpu_ack_q, cpu_ack_d;

   // data / address state
   logic [29:0]   mem_adr_q, mem_adr_d;
   logic [29:0]   nxt_adr_q, nxt_adr_d;
   logic [31:0]   cpu_rdt_q, cpu_rdt_d;
   logic [29:0]   fifo_adr_q [DEPTH];
   logic [29:0]   fifo_adr_d [DEPTH];
   logic [31:0]   fifo_dat_q [DEPTH];
   logic [31:0]   fifo_dat_d [DEPTH];

   logic req, fifo_empty, hit, mem_wait, miss, mem_done, clear, push, pop, issue_seq;

   // Word-aligned fetches only; the byte offset carries no information here.
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^i_cpu_adr[1:0];

   always_comb begin
      // The ack cycle is masked: the core still holds cyc while it consumes the word.
      req        = i_cpu_cyc & ~cpu_ack_q;
      fifo_empty = (count_q == '0);
      // A flush invalidates the buffered words, so it also blocks a hit in the same cycle.
      hit        = req & ~i_flush & ~fifo_empty & (fifo_adr_q[rd_ptr_q] == i_cpu_adr[31:2]);
      // Requested word is the one already on the bus and will be kept: just wait for it.
      mem_wait   = req & fifo_empty & mem_cyc_q & ~drop_q & (mem_adr_q == i_cpu_adr[31:2]);
      miss       = req & ~hit & ~mem_wait;
      mem_done   = mem_cyc_q & i_mem_ack;
      clear      = miss | i_flush;
      push       = mem_done & ~drop_q & ~clear;
      pop        = hit;
   end

   // FIFO pointers, occupancy and storage
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      fifo_adr_d = fifo_adr_q;
      fifo_dat_d = fifo_dat_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_adr_d[wr_ptr_q] = mem_adr_q;
            fifo_dat_d[wr_ptr_q] = i_mem_rdt;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Sequential prefetch: one outstanding fetch, launched only if its word will fit
   // once it returns (count_d already accounts for this cycle's push and pop).
   assign issue_seq = ~mem_cyc_q & started_q & ~drop_q & ~clear & (count_d < DEPTH_C);

   // Memory side and prefetch bookkeeping
   always_comb begin
      mem_cyc_d = mem_cyc_q;
      mem_adr_d = mem_adr_q;
      nxt_adr_d = nxt_adr_q;
      drop_d    = drop_q;
      started_d = started_q;

      if (mem_done) begin
         mem_cyc_d = 1'b0;
         drop_d    = 1'b0;
         if (push) begin
            nxt_adr_d = nxt_adr_q + 30'd1;   // wraps 0x3FFFFFFF -> 0
         end
      end

      // Wishbone classic cannot be aborted: remember to discard the outstanding word.
      // If it is acknowledged this very cycle it is simply not pushed instead.
      if (clear & mem_cyc_q & ~mem_done) begin
         drop_d = 1'b1;
      end

      if (miss) begin
         nxt_adr_d = i_cpu_adr[31:2];
         started_d = 1'b1;
      end
      if (i_flush) begin
         started_d = 1'b0;
      end

      // A miss with an idle bus fetches the requested word directly; otherwise the
      // refetch happens through the sequential path once the bus is free.
      if (miss & ~i_flush & ~mem_cyc_q) begin
         mem_cyc_d = 1'b1;
         mem_adr_d = i_cpu_adr[31:2];
      end else if (issue_seq) begin
         mem_cyc_d = 1'b1;
         mem_adr_d = nxt_adr_q;
      end
   end

   // Core side
   always_comb begin
      cpu_ack_d = hit;
      cpu_rdt_d = cpu_rdt_q;
      if (hit) begin
         cpu_rdt_d = fifo_dat_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         mem_cyc_q <= 1'b0;
         drop_q    <= 1'b0;
         started_q <= 1'b0;
         cpu_ack_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         mem_cyc_q <= mem_cyc_d;
         drop_q    <= drop_d;
         started_q <= started_d;
         cpu_ack_q <= cpu_ack_d;
      end
   end

   generate
      if (RESET_STRATEGY == "NONE") begin : g_data_noreset
         always_ff @(posedge clk) begin
            mem_adr_q  <= mem_adr_d;
            nxt_adr_q  <= nxt_adr_d;
            cpu_rdt_q  <= cpu_rdt_d;
            fifo_adr_q <= fifo_adr_d;
            fifo_dat_q <= fifo_dat_d;
         end
      end else begin : g_data_reset
         always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               mem_adr_q <= '0;
               nxt_adr_q <= '0;
               cpu_rdt_q <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  fifo_adr_q[i] <= '0;
                  fifo_dat_q[i] <= '0;
               end
            end else begin
               mem_adr_q  <= mem_adr_d;
               nxt_adr_q  <= nxt_adr_d;
               cpu_rdt_q  <= cpu_rdt_d;
               fifo_adr_q <= fifo_adr_d;
               fifo_dat_q <= fifo_dat_d;
            end
         end
      end
   endgenerate

   assign o_cpu_ack = cpu_ack_q;
   assign o_cpu_rdt = cpu_rdt_q;
   assign o_mem_cyc = mem_cyc_q;
   assign o_mem_adr = {mem_adr_q, 2'b00};

endmodule

// File: tb/tb_qerv_ibus_prefetch.sv
// Purpose : self-checking bench for qerv_ibus_prefetch; core requests feed a scoreboard,
//           a monitor checks every core acknowledge, a memory model answers the fetches.
// Memory  : word data is a fixed function of address and a write epoch, latched when a fetch starts.
module tb_qerv_ibus_prefetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_flush;
   logic [31:0] i_cpu_adr;
   logic        i_cpu_cyc;
   logic [31:0] o_cpu_rdt;
   logic        o_cpu_ack;
   logic [31:0] o_mem_adr;
   logic        o_mem_cyc;
   logic [31:0] i_mem_rdt;
   logic        i_mem_ack;

   always #5 clk = ~clk;

   qerv_ibus_prefetch #(.DEPTH(2), .RESET_STRATEGY("MINI")) dut (
      .clk       (clk),
      .i_rst_n   (rst_n),
      .i_flush   (i_flush),
      .i_cpu_adr (i_cpu_adr),
      .i_cpu_cyc (i_cpu_cyc),
      .o_cpu_rdt (o_cpu_rdt),
      .o_cpu_ack (o_cpu_ack),
      .o_mem_adr (o_mem_adr),
      .o_mem_cyc (o_mem_cyc),
      .i_mem_rdt (i_mem_rdt),
      .i_mem_ack (i_mem_ack)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      int          lat;   // expected req->ack cycles, -1 = not checked
      int          t0;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_log[$];
   int          n_cmp   = 0;
   int          n_fail  = 0;
   int          cyc_cnt = 0;
   int          mem_lat = 1;
   logic [7:0]  epoch   = 8'd0;

   always @(posedge clk) cyc_cnt++;

   function automatic logic [31:0] mdat(input logic [31:0] a, input logic [7:0] ep);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E3779B1) ^ 32'h13579BDF ^ {ep, 24'h000000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
      if (idx < mem_log.size()) begin
         chk(name, mem_log[idx], exp);
      end else begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: memory request #%0d never issued, expected %h", name, idx, exp);
      end
   endtask

   // ---------------- memory model (Wishbone classic slave) ----------------
   int          mcnt = 0;
   logic [31:0] mlatch;
   initial begin
      i_mem_ack = 1'b0;
      i_mem_rdt = 32'hDEADBEEF;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            i_mem_ack = 1'b0;
            mcnt      = 0;
         end else if (i_mem_ack) begin
            i_mem_ack = 1'b0;
            i_mem_rdt = 32'hDEADBEEF;
            mcnt      = 0;
         end else if (o_mem_cyc) begin
            if (mcnt == 0) begin
               mem_log.push_back(o_mem_adr);
               mlatch = mdat(o_mem_adr, epoch);
               chk("mem_adr_align", {30'd0, o_mem_adr[1:0]}, 32'd0);
            end
            if (mcnt >= mem_lat) begin
               i_mem_ack = 1'b1;
               i_mem_rdt = mlatch;
            end else begin
               mcnt++;
            end
         end
      end
   end

   // ---------------- monitor: every core ack is checked against the scoreboard ----------------
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_cpu_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ack: rdt %h, expected no acknowledge", o_cpu_rdt);
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("rdt@%h", mon_e.adr), o_cpu_rdt, mon_e.dat);
            if (mon_e.lat >= 0) begin
               chk($sformatf("lat@%h", mon_e.adr), 32'(cyc_cnt - mon_e.t0), 32'(mon_e.lat));
            end
         end
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fetch(input logic [31:0] adr, input int lat);
      exp_t e;
      logic got;
      e.adr = adr;
      e.dat = mdat(adr, epoch);
      e.lat = lat;
      e.t0  = cyc_cnt;
      exp_q.push_back(e);
      i_cpu_adr = adr;
      i_cpu_cyc = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(posedge clk);
         #1;
         if (o_cpu_ack) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL fetch_timeout@%h: no ack within 300 cycles, expected ack", adr);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      i_cpu_cyc = 1'b0;
   endtask

   task automatic flush_pulse(input logic bump);
      i_flush = 1'b1;
      if (bump) epoch = epoch + 8'd1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int          s;
   int          r;
   logic        found;
   logic [31:0] a;
   logic [31:0] last;

   initial begin
      rst_n     = 1'b0;
      i_flush   = 1'b0;
      i_cpu_cyc = 1'b0;
      i_cpu_adr = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_ack", {31'd0, o_cpu_ack}, 32'd0);
      chk("rst_mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
      chk("rst_mem_adr", o_mem_adr, 32'd0);
      chk("rst_cpu_rdt", o_cpu_rdt, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // nothing is fetched before the first core request
      idle(6);
      chk("no_prefetch_log", mem_log.size(), 32'd0);
      chk("no_prefetch_cyc", {31'd0, o_mem_cyc}, 32'd0);

      // 1: first miss, L=1 -> ack 4 cycles after request, then prefetch 0x4, 0x8 until full
      mem_lat = 1;
      fetch(32'h0, 4);
      idle(8);
      chk("t1_log_size", mem_log.size(), 32'd3);
      chk_log("t1_log0", 0, 32'h0);
      chk_log("t1_log1", 1, 32'h4);
      chk_log("t1_log2", 2, 32'h8);
      chk("t1_full_blocks", {31'd0, o_mem_cyc}, 32'd0);

      // 2/4: sequential hits; push of 0xC coincides with the pop of 0x8
      fetch(32'h4, 1);
      fetch(32'h8, 1);
      fetch(32'hC, 1);
      fetch(32'h10, 1);
      chk_log("t2_log3", 3, 32'hC);
      chk_log("t2_log4", 4, 32'h10);

      // 3: jump while the 0x1C prefetch is in flight
      idle(12);
      mem_lat = 3;
      fetch(32'h14, 1);
      s = mem_log.size();
      chk_log("t3_inflight", s - 1, 32'h1C);
      fetch(32'h100, -1);
      chk_log("t3_refetch", s, 32'h100);

      // 5: address wrap
      mem_lat = 1;
      idle(15);
      s = mem_log.size();
      fetch(32'hFFFFFFF8, 4);
      idle(10);
      chk_log("t5_log0", s, 32'hFFFFFFF8);
      chk_log("t5_log1", s + 1, 32'hFFFFFFFC);
      chk_log("t5_log2", s + 2, 32'h00000000);
      fetch(32'hFFFFFFFC, 1);
      fetch(32'h0, 1);

      // 6: flush while 0x20 is in flight, memory contents change (new epoch)
      mem_lat = 3;
      idle(15);
      fetch(32'h18, -1);
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (o_mem_cyc && o_mem_adr == 32'h20) found = 1'b1;
         else idle(1);
      end
      if (!found) begin
         n_cmp++;
         n_fail++;
         $display("FAIL t6_wait_inflight: no fetch of 00000020 seen, expected one");
      end
      idle(1);
      s = mem_log.size();
      flush_pulse(1'b1);
      idle(8);
      chk("t6_no_restart", mem_log.size(), 32'(s));
      chk("t6_bus_idle", {31'd0, o_mem_cyc}, 32'd0);
      fetch(32'h20, 6);
      chk_log("t6_fresh_fetch", s, 32'h20);
      fetch(32'h24, -1);

      // randomized traffic: sequential runs, short jumps, far jumps, flushes, varying latency
      last = 32'h24;
      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55)      a = last + 32'd4;
         else if (r < 80) a = last - 32'd12 + (32'($urandom_range(0, 6)) << 2);
         else             a = $urandom;
         a[1:0]  = 2'($urandom_range(0, 3));
         last    = {a[31:2], 2'b00};
         mem_lat = int'($urandom_range(1, 4));
         fetch(a, -1);
         idle(int'($urandom_range(0, 3)));
         if ($urandom_range(0, 15) == 0) flush_pulse(1'($urandom_range(0, 1)));
      end

      idle(20);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
